// File: rtl/user_id_readout.sv
// Samples the mask-programmed user project ID until stable, latches it for parallel readback
// and streams it MSB-first on a framed serial link followed by an even-parity bit.
module user_id_readout #(
  parameter int unsigned ID_WIDTH   = 32,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned STABLE_CNT = 2,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  input  logic [ID_WIDTH-1:0] mask_rev,
  input  logic                req_i,
  output logic                busy_o,
  output logic [ID_WIDTH-1:0] id_o,
  output logic                id_valid_o,
  output logic                ser_frame_o,
  output logic                ser_clk_o,
  output logic                ser_dat_o,
  output logic                done_o,
  output logic                err_o
);

  localparam int unsigned MatchW = $clog2(STABLE_CNT + 1);
  localparam int unsigned TmoW   = $clog2(TIMEOUT);
  localparam int unsigned BitW   = $clog2(ID_WIDTH);
  localparam int unsigned PhW    = $clog2(CLK_DIV);

  typedef enum logic [2:0] {
    StIdle,
    StSample,
    StShift,
    StParity,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] prev_q, prev_d;
  logic [MatchW-1:0]   match_q, match_d;
  logic [TmoW-1:0]     tmo_q, tmo_d;
  logic [ID_WIDTH-1:0] shift_q, shift_d;
  logic                par_q, par_d;
  logic [BitW-1:0]     bit_q, bit_d;
  logic [PhW-1:0]      ph_q, ph_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;

  logic last_phase;
  assign last_phase = (ph_q == PhW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    match_d = match_q;
    tmo_d   = tmo_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    ph_d    = ph_q;
    id_d    = id_q;
    valid_d = valid_q;
    err_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_i) begin
          prev_d  = mask_rev;
          match_d = '0;
          tmo_d   = '0;
          state_d = StSample;
        end
      end
      StSample: begin
        // Stability wins over a timeout that expires on the same cycle.
        if (match_q == MatchW'(STABLE_CNT)) begin
          id_d    = prev_q;
          valid_d = 1'b1;
          shift_d = prev_q;
          par_d   = ^prev_q;
          bit_d   = '0;
          ph_d    = '0;
          state_d = StShift;
        end else if (tmo_q == TmoW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          match_d = (mask_rev == prev_q) ? match_q + MatchW'(1) : '0;
          prev_d  = mask_rev;
          tmo_d   = tmo_q + TmoW'(1);
        end
      end
      StShift: begin
        if (last_phase) begin
          ph_d    = '0;
          shift_d = shift_q << 1;
          if (bit_q == BitW'(ID_WIDTH - 1)) begin
            state_d = StParity;
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end else begin
          ph_d = ph_q + PhW'(1);
        end
      end
      StParity: begin
        if (last_phase) begin
          ph_d    = '0;
          state_d = StDone;
        end else begin
          ph_d = ph_q + PhW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      prev_q  <= '0;
      match_q <= '0;
      tmo_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      ph_q    <= '0;
      id_q    <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      match_q <= match_d;
      tmo_q   <= tmo_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      id_q    <= id_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  logic in_frame;
  assign in_frame = (state_q == StShift) || (state_q == StParity);

  assign busy_o      = busy_q;
  assign id_o        = id_q;
  assign id_valid_o  = valid_q;
  assign err_o       = err_q;
  assign done_o      = (state_q == StDone);
  assign ser_frame_o = in_frame;
  assign ser_clk_o   = in_frame && (ph_q >= PhW'(CLK_DIV / 2));
  assign ser_dat_o   = (state_q == StShift)  ? shift_q[ID_WIDTH-1] :
                       (state_q == StParity) ? par_q : 1'b0;

endmodule

// File: tb/tb_user_id_readout.sv
// Scoreboard bench for user_id_readout: stimulus queues expected frames/aborts, a negedge
// monitor reassembles each serial frame and checks it against the queued expectation.
module tb_user_id_readout;

  localparam int unsigned W        = 32;
  localparam int unsigned DIV      = 4;
  localparam int unsigned STABLE   = 2;
  localparam int unsigned TMO      = 16;
  localparam int unsigned FrameLen = (W + 1) * DIV;

  logic         clk = 1'b0;
  logic         rst;
  logic         req;
  logic [W-1:0] mask;
  logic         busy_o, id_valid_o, ser_frame_o, ser_clk_o, ser_dat_o, done_o, err_o;
  logic [W-1:0] id_o;

  user_id_readout #(
    .ID_WIDTH  (W),
    .CLK_DIV   (DIV),
    .STABLE_CNT(STABLE),
    .TIMEOUT   (TMO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .mask_rev   (mask),
    .req_i      (req),
    .busy_o     (busy_o),
    .id_o       (id_o),
    .id_valid_o (id_valid_o),
    .ser_frame_o(ser_frame_o),
    .ser_clk_o  (ser_clk_o),
    .ser_dat_o  (ser_dat_o),
    .done_o     (done_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit           is_err;
    logic [W-1:0] id;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           frames_seen = 0;
  int           errs_seen = 0;
  logic [W-1:0] model_id = '0;
  bit           model_valid = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic fail_now(string name);
    checks++;
    errors++;
    $display("FAIL %s: event not seen within bound", name);
  endtask

  // Monitor: reassembles frames and consumes scoreboard entries.
  bit         mon_in_frame = 1'b0;
  int         fcnt = 0;
  logic [W:0] bits;
  bit         clk_bad, dat_bad;
  exp_t       e;

  always @(negedge clk) begin
    if (rst) begin
      mon_in_frame = 1'b0;
      fcnt = 0;
    end else begin
      if (ser_frame_o) begin
        if (!mon_in_frame) begin
          mon_in_frame = 1'b1;
          fcnt = 0;
          clk_bad = 1'b0;
          dat_bad = 1'b0;
          bits = '0;
        end
        if (ser_clk_o !== ((fcnt % DIV) >= (DIV / 2))) clk_bad = 1'b1;
        if ((fcnt % DIV) == 0) bits = {bits[W-1:0], ser_dat_o};
        else if (ser_dat_o !== bits[0]) dat_bad = 1'b1;
        fcnt++;
      end else begin
        check("idle_serial", {ser_clk_o, ser_dat_o}, 0);
        if (mon_in_frame) begin
          mon_in_frame = 1'b0;
          check("frame_len", fcnt, FrameLen);
          check("done_after_frame", done_o, 1);
          check("ser_clk_shape", clk_bad, 0);
          check("bit_stable", dat_bad, 0);
          if (exp_q.size() == 0) begin
            fail_now("unexpected_frame");
          end else begin
            e = exp_q.pop_front();
            check("frame_kind", e.is_err, 0);
            check("frame_data", bits, {e.id, ^e.id});
            check("id_o", id_o, e.id);
            check("id_valid_o", id_valid_o, 1);
            model_id = e.id;
            model_valid = 1'b1;
          end
          frames_seen++;
        end else begin
          check("stray_done", done_o, 0);
        end
      end
      if (err_o) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_err");
        end else begin
          e = exp_q.pop_front();
          check("err_kind", e.is_err, 1);
        end
        check("err_busy", busy_o, 0);
        check("err_done_excl", done_o, 0);
        check("err_id_o", id_o, model_id);
        check("err_id_valid", id_valid_o, model_valid);
        errs_seen++;
      end
    end
  end

  // One request with constant mask_rev; optionally changes mask_rev and pulses req mid-frame.
  task automatic run_frame(logic [W-1:0] id, int change_at, logic [W-1:0] new_mask);
    int f0 = frames_seen;
    int lat = 0;
    int n = 0;
    @(posedge clk); #1 mask = id; req = 1'b1;
    exp_q.push_back('{1'b0, id});
    @(posedge clk); #1 req = 1'b0;
    check("busy_after_req", busy_o, 1);
    while (!ser_frame_o && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("shift_latency", lat, STABLE + 1);
    while (frames_seen == f0 && n < 400) begin
      if (change_at > 0 && n == change_at) begin
        mask = new_mask;
        req = 1'b1;
      end else begin
        req = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    req = 1'b0;
    if (frames_seen == f0) fail_now("frame_timeout");
  endtask

  task automatic run_timeout();
    int e0 = errs_seen;
    int n = 0;
    @(posedge clk); #1 mask = '0; req = 1'b1;
    exp_q.push_back('{1'b1, '0});
    @(posedge clk); #1 req = 1'b0; mask = ~mask;
    while (!err_o && n < 40) begin
      @(posedge clk); #1 mask = ~mask;
      n++;
    end
    check("err_latency", n, TMO);
    repeat (2) @(posedge clk);
    #1;
    check("err_count", errs_seen, e0 + 1);
    check("busy_after_err", busy_o, 0);
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_id"}, id_o, 0);
    check({tag, "_valid"}, id_valid_o, 0);
    check({tag, "_frame"}, ser_frame_o, 0);
    check({tag, "_sclk"}, ser_clk_o, 0);
    check({tag, "_sdat"}, ser_dat_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_err"}, err_o, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] rid;
    int           f0;
    int           n;
    rst = 1'b1;
    req = 1'b0;
    mask = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    run_timeout();
    run_frame(32'hA5A5_0001, 0, '0);
    run_frame(32'h0000_0000, 0, '0);
    run_frame(32'h1234_5678, 50, 32'hFFFF_FFFF);

    for (int i = 0; i < 8; i++) begin
      rid = $urandom;
      if ($urandom_range(0, 1) == 1) run_frame(rid, $urandom_range(1, 120), $urandom);
      else run_frame(rid, 0, '0);
      repeat ($urandom_range(0, 5)) @(posedge clk);
    end

    // Reset at the start of bit 10 of a frame.
    @(posedge clk); #1 mask = 32'hDEAD_BEEF; req = 1'b1;
    exp_q.push_back('{1'b0, 32'hDEAD_BEEF});
    @(posedge clk); #1 req = 1'b0;
    n = 0;
    while (!ser_frame_o && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ser_frame_o) fail_now("frame_start");
    repeat (10 * DIV) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    model_id = '0;
    model_valid = 1'b0;
    check_all_zero("midreset");
    run_frame(32'hCAFE_F00D, 0, '0);

    // Held request: back-to-back frames with one idle cycle between them.
    f0 = frames_seen;
    rid = $urandom;
    exp_q.push_back('{1'b0, rid});
    exp_q.push_back('{1'b0, rid});
    @(posedge clk); #1 mask = rid; req = 1'b1;
    n = 0;
    while (!done_o && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_o) fail_now("b2b_done1");
    @(posedge clk); #1;
    check("b2b_gap_idle", busy_o, 0);
    @(posedge clk); #1;
    check("b2b_restart", busy_o, 1);
    n = 0;
    while (!done_o && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done_o) fail_now("b2b_done2");
    req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("b2b_frames", frames_seen, f0 + 2);
    check("b2b_idle_after", busy_o, 0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
